coso_beat_counter: RTL and testbench

//  Receive side of the toggle/sampling front end of the COSO TRNG.
//  - Takes the asynchronous beat signal, synchronises it and detects its rising edges.
//  - Counts clk cycles between consecutive rising edges.
//  - Emits the count LSBs as raw random bits over a valid/ready interface to the post-processing/readout logic.
//  - Also exposes the full period for online health monitoring.

---
 rtl/coso_beat_counter.sv | 128 ++++++++++++
 tb/tb_coso_beat_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coso_beat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// coso_beat_counter : measures clk cycles between COSO beat rising edges and
// emits the period LSBs as raw random bits over valid/ready.   Rev 1.0
// ----------------------------------------------------------------------------
module coso_beat_counter #(
   parameter int CNT_W       = 16,
   parameter int NB_BITS     = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               en,
   input  logic               beatIn,
   output logic [NB_BITS-1:0] rndOut,
   output logic [CNT_W-1:0]   cntOut,
   output logic               rndValid,
   input  logic               rndReady,
   output logic               satErr,
   output logic               dropErr
);

   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
   localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      COUNT = 2'd2
   } state_t;

   state_t                   state_q;
   logic [SYNC_STAGES-1:0]   sync_q;
   logic                     prev_q;
   logic                     rise_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [NB_BITS-1:0]       rnd_out_q;
   logic [CNT_W-1:0]         cnt_out_q;
   logic                     rnd_valid_q;
   logic                     sat_err_q;
   logic                     drop_err_q;

   logic                     rise_d;
   logic                     cnt_sat_d;
   logic [CNT_W-1:0]         cnt_inc_d;
   logic                     xfer_d;
   logic                     can_load_d;

   // The edge pulse is registered once more so every capture decision sees a
   // clean, glitch-free flop output; this sets the SYNC_STAGES+1 latency.
   assign rise_d     = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign cnt_sat_d  = (cnt_q == C_CNT_MAX);
   assign cnt_inc_d  = cnt_sat_d ? cnt_q : (cnt_q + C_CNT_ONE);
   assign xfer_d     = rnd_valid_q & rndReady;
   assign can_load_d = ~rnd_valid_q | rndReady;

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= IDLE;
         sync_q      <= '0;
         prev_q      <= 1'b0;
         rise_q      <= 1'b0;
         cnt_q       <= '0;
         rnd_out_q   <= '0;
         cnt_out_q   <= '0;
         rnd_valid_q <= 1'b0;
         sat_err_q   <= 1'b0;
         drop_err_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], beatIn};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= rise_d;

         if (xfer_d) begin
            rnd_valid_q <= 1'b0;
         end

         if (!en) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= ARM;
               end
               ARM: begin
                  if (rise_q) begin
                     state_q <= COUNT;
                     cnt_q   <= C_CNT_ONE;
                  end
               end
               COUNT: begin
                  if (rise_q) begin
                     cnt_q <= C_CNT_ONE;
                     // A saturated period carries no entropy worth emitting.
                     if (cnt_sat_d) begin
                        sat_err_q <= 1'b1;
                     end else if (can_load_d) begin
                        cnt_out_q   <= cnt_q;
                        rnd_out_q   <= cnt_q[NB_BITS-1:0];
                        rnd_valid_q <= 1'b1;
                     end else begin
                        drop_err_q <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_inc_d;
                     if (cnt_inc_d == C_CNT_MAX) begin
                        sat_err_q <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign rndOut   = rnd_out_q;
   assign cntOut   = cnt_out_q;
   assign rndValid = rnd_valid_q;
   assign satErr   = sat_err_q;
   assign dropErr  = drop_err_q;

endmodule
`default_nettype wire

// File: tb/tb_coso_beat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_coso_beat_counter : directed bench for coso_beat_counter (CNT_W 16 and 4)
// against a period-arithmetic reference model.   Rev 1.0
// ----------------------------------------------------------------------------
module tb_coso_beat_counter;

   logic        clk;
   logic        clr;
   logic        en;
   logic        beatIn;
   logic        rndReady;

   logic [0:0]  rnd16;
   logic [15:0] cnt16;
   logic        v16, sat16, drop16;
   logic [0:0]  rnd4;
   logic [3:0]  cnt4;
   logic        v4, sat4, drop4;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int nv16 = 0, nv4 = 0;
   int last16 = 0, last4 = 0;
   int lastr16 = 0, lastr4 = 0;

   coso_beat_counter dut16 (
      .clk(clk), .clr(clr), .en(en), .beatIn(beatIn),
      .rndOut(rnd16), .cntOut(cnt16), .rndValid(v16), .rndReady(rndReady),
      .satErr(sat16), .dropErr(drop16)
   );

   coso_beat_counter #(.CNT_W(4), .NB_BITS(1), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .clr(clr), .en(en), .beatIn(beatIn),
      .rndOut(rnd4), .cntOut(cnt4), .rndValid(v4), .rndReady(rndReady),
      .satErr(sat4), .dropErr(drop4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: phase 0 idle, 1 armed, 2 measuring since edge index tl.
   // hv[k] holds the beatIn sample taken k+1 edges ago; a rise acts once it
   // has crossed the two synchroniser stages and the edge-detect register.
   typedef struct {
      bit [3:0] hv;
      int       phase;
      int       tl;
      bit       valid;
      int       cnt_out;
      bit       sat;
      bit       drop;
   } mdl_t;

   mdl_t m16, m4;

   function automatic mdl_t step(input mdl_t m, input int maxv, input int e,
                                 input bit c, input bit en_v, input bit b,
                                 input bit rdy);
      mdl_t n;
      bit   rise;
      int   d;
      n = m;
      if (c) begin
         n.hv = '0; n.phase = 0; n.tl = 0; n.valid = 1'b0;
         n.cnt_out = 0; n.sat = 1'b0; n.drop = 1'b0;
         return n;
      end
      rise = m.hv[2] & ~m.hv[3];
      n.hv = {m.hv[2:0], b};
      if (m.valid && rdy) n.valid = 1'b0;
      if (!en_v) begin
         n.phase = 0;
      end else if (m.phase == 0) begin
         n.phase = 1;
      end else if (m.phase == 1) begin
         if (rise) begin
            n.phase = 2;
            n.tl = e;
         end
      end else begin
         if (rise) begin
            d = e - m.tl;
            n.tl = e;
            if (d >= maxv) n.sat = 1'b1;
            else if (!m.valid || rdy) begin
               n.valid = 1'b1;
               n.cnt_out = d;
            end else n.drop = 1'b1;
         end else if (e - m.tl + 1 >= maxv) begin
            n.sat = 1'b1;
         end
      end
      return n;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always begin
      @(posedge clk);
      cyc++;
      m16 = step(m16, 65535, cyc, clr, en, beatIn, rndReady);
      m4  = step(m4, 15, cyc, clr, en, beatIn, rndReady);
      #1;
      chk("v16",    {31'd0, v16},    {31'd0, m16.valid});
      chk("cnt16",  {16'd0, cnt16},  m16.cnt_out);
      chk("rnd16",  {31'd0, rnd16},  m16.cnt_out % 2);
      chk("sat16",  {31'd0, sat16},  {31'd0, m16.sat});
      chk("drop16", {31'd0, drop16}, {31'd0, m16.drop});
      chk("v4",     {31'd0, v4},     {31'd0, m4.valid});
      chk("cnt4",   {28'd0, cnt4},   m4.cnt_out);
      chk("rnd4",   {31'd0, rnd4},   m4.cnt_out % 2);
      chk("sat4",   {31'd0, sat4},   {31'd0, m4.sat});
      chk("drop4",  {31'd0, drop4},  {31'd0, m4.drop});
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (v16 === 1'b1) begin nv16++; last16 = int'(cnt16); lastr16 = int'(rnd16); end
         if (v4 === 1'b1)  begin nv4++;  last4 = int'(cnt4);   lastr4 = int'(rnd4);   end
      end
   endtask

   task automatic beat_period(input int p);
      beatIn = 1'b1;
      tick(p / 2);
      beatIn = 1'b0;
      tick(p - p / 2);
   endtask

   initial begin
      clr = 1'b1; en = 1'b0; beatIn = 1'b0; rndReady = 1'b0;
      tick(3);
      chk("rst_valid", {31'd0, v16},    32'd0);
      chk("rst_cnt",   {16'd0, cnt16},  32'd0);
      chk("rst_sat4",  {31'd0, sat4},   32'd0);
      clr = 1'b0; en = 1'b1; rndReady = 1'b1;
      tick(2);

      // Steady stream, period 37: first rise arms, three words follow.
      nv16 = 0;
      for (int k = 0; k < 4; k++) beat_period(37);
      chk("stream_words", nv16,    32'd3);
      chk("stream_cnt",   last16,  32'd37);
      chk("stream_rnd",   lastr16, 32'd1);
      chk("stream_drop",  {31'd0, drop16}, 32'd0);
      chk("model_cnt",    m16.cnt_out, 32'd37);

      // Latency: rndValid rises on the third edge after beatIn is sampled.
      beatIn = 1'b1;
      tick(1);
      tick(2);
      chk("lat_n2", {31'd0, v16}, 32'd0);
      tick(1);
      chk("lat_n3",     {31'd0, v16},   32'd1);
      chk("lat_n3_cnt", {16'd0, cnt16}, 32'd37);
      tick(14);
      beatIn = 1'b0;
      tick(19);

      // Backpressure: first word held, next two periods dropped.
      rndReady = 1'b0;
      for (int k = 0; k < 3; k++) beat_period(37);
      chk("bp_valid", {31'd0, v16},    32'd1);
      chk("bp_cnt",   {16'd0, cnt16},  32'd37);
      chk("bp_drop",  {31'd0, drop16}, 32'd1);
      rndReady = 1'b1;
      tick(1);
      chk("bp_drain", {31'd0, v16}, 32'd0);

      // Reset mid-activity with beatIn high; the post-reset rise only arms.
      beatIn = 1'b1;
      tick(5);
      clr = 1'b1;
      tick(2);
      chk("mid_rst_valid", {31'd0, v16},    32'd0);
      chk("mid_rst_cnt",   {16'd0, cnt16},  32'd0);
      chk("mid_rst_drop",  {31'd0, drop16}, 32'd0);
      chk("mid_rst_sat4",  {31'd0, sat4},   32'd0);
      clr = 1'b0;
      nv16 = 0; nv4 = 0;
      tick(11);
      beatIn = 1'b0;
      tick(19);
      chk("rst_arm_only", nv16, 32'd0);

      // Saturation on the 4-bit counter, then a period that fits.
      beat_period(20);
      beat_period(20);
      beat_period(10);
      chk("sat_flag4",  {31'd0, sat4}, 32'd1);
      chk("sat_words4", nv4,           32'd0);
      chk("sat_flag16", {31'd0, sat16}, 32'd0);
      beat_period(10);
      chk("sat_after_words4", nv4,    32'd1);
      chk("sat_after_cnt4",   last4,  32'd10);
      chk("sat_after_rnd4",   lastr4, 32'd0);

      // Enable dropped mid-period for 5 cycles.
      beat_period(37);
      beatIn = 1'b1;
      tick(15);
      nv16 = 0;
      en = 1'b0;
      tick(3);
      beatIn = 1'b0;
      tick(2);
      en = 1'b1;
      tick(17);
      beat_period(37);
      chk("en_arm_only", nv16, 32'd0);
      beat_period(37);
      chk("en_words", nv16,   32'd1);
      chk("en_cnt",   last16, 32'd37);

      // Transfer and capture in the same cycle.
      rndReady = 1'b0;
      beat_period(41);
      beatIn = 1'b1;
      tick(3);
      rndReady = 1'b1;
      tick(1);
      chk("sim_valid", {31'd0, v16},    32'd1);
      chk("sim_cnt",   {16'd0, cnt16},  32'd41);
      chk("sim_drop",  {31'd0, drop16}, 32'd0);
      tick(1);
      chk("sim_drain", {31'd0, v16}, 32'd0);
      beatIn = 1'b0;
      tick(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
